// File: rtl/tpfu_core.sv
// tpfu_core: temporally-programmed functional unit. It loads a burst into a register file,
// runs a stored program through a fixed-latency ALU pipe, and streams out tagged results.
// Optional: define TPFU_WRITEBACK_EN to also write each result back into the register file.
module tpfu_core #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 6,
  parameter int PC_W     = 4,
  parameter int PIPE_LAT = 3,
  parameter int INST_W   = 3 + 3*ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [INST_W-1:0] prog_data,
  input  logic [PC_W:0]     num_inst,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] dout_dst,
  output logic              dout_v,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {LOAD, EXEC, DRAIN} state_t;

  localparam int REGS = 2**ADDR_W;
  localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [PC_W:0] MAX_INST = (PC_W+1)'(2**PC_W);

  logic [DATA_W-1:0] regfile [REGS];
  logic [INST_W-1:0] imem [2**PC_W];

  state_t            state;
  logic [ADDR_W:0]   wr_cnt;
  logic [PC_W:0]     pc;
  logic [PC_W:0]     n_inst;
  logic [PC_W:0]     num_clamped;
  logic [CNT_W-1:0]  drain_cnt;

  logic [INST_W-1:0] inst;
  logic [2:0]        op;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu;
  logic              res_v;

  logic              p_v [PIPE_LAT];
  logic [DATA_W-1:0] p_d [PIPE_LAT];
  logic [ADDR_W-1:0] p_t [PIPE_LAT];

  assign num_clamped = (num_inst > MAX_INST) ? MAX_INST : num_inst;
  assign inst = imem[pc[PC_W-1:0]];
  assign {op, dst, src1, src2} = inst;
  assign a = regfile[src1];
  assign b = regfile[src2];
  assign imm = DATA_W'(src2);
  assign res_v = (state == EXEC) && (op != 3'b000);

  always_comb begin
    alu = '0;
    case (op)
      3'b001:  alu = a + b;
      3'b010:  alu = a - b;
      3'b011:  alu = a * b;
      3'b100:  alu = a;
      3'b101:  alu = a + imm;
      3'b110:  alu = a - imm;
      3'b111:  alu = a * imm;
      default: alu = '0;
    endcase
  end

  // Storage is deliberately not reset so data and program survive an aborted run.
  always_ff @(posedge clk) begin
    if (state == LOAD && din_valid && !wr_cnt[ADDR_W])
      regfile[wr_cnt[ADDR_W-1:0]] <= din;
`ifdef TPFU_WRITEBACK_EN
    else if (p_v[PIPE_LAT-1])
      regfile[p_t[PIPE_LAT-1]] <= p_d[PIPE_LAT-1];
`endif
    if (state == LOAD && prog_we)
      imem[prog_addr] <= prog_data;
  end

  // Data and tag only advance with a valid result, so the last stage holds its value over bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        p_v[i] <= 1'b0;
        p_d[i] <= '0;
        p_t[i] <= '0;
      end
    end else begin
      p_v[0] <= res_v;
      if (res_v) begin
        p_d[0] <= alu;
        p_t[0] <= dst;
      end
      for (int i = 1; i < PIPE_LAT; i++) begin
        p_v[i] <= p_v[i-1];
        if (p_v[i-1]) begin
          p_d[i] <= p_d[i-1];
          p_t[i] <= p_t[i-1];
        end
      end
    end
  end

  assign dout     = p_d[PIPE_LAT-1];
  assign dout_dst = p_t[PIPE_LAT-1];
  assign dout_v   = p_v[PIPE_LAT-1];

  // DRAIN always lasts PIPE_LAT cycles; done marks its final cycle, when the last result leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      wr_cnt    <= '0;
      pc        <= '0;
      n_inst    <= '0;
      drain_cnt <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      din_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          if (din_valid) begin
            if (wr_cnt[ADDR_W])
              ovf <= 1'b1;
            else
              wr_cnt <= wr_cnt + (ADDR_W+1)'(1);
          end else if (wr_cnt != '0) begin
            wr_cnt    <= '0;
            pc        <= '0;
            n_inst    <= num_clamped;
            busy      <= 1'b1;
            din_ready <= 1'b0;
            if (num_clamped == '0) begin
              state     <= DRAIN;
              drain_cnt <= CNT_W'(PIPE_LAT-1);
              done      <= (PIPE_LAT == 1);
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          pc <= pc + (PC_W+1)'(1);
          if (pc == n_inst - (PC_W+1)'(1)) begin
            state     <= DRAIN;
            drain_cnt <= CNT_W'(PIPE_LAT-1);
            done      <= (PIPE_LAT == 1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state     <= LOAD;
            busy      <= 1'b0;
            din_ready <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
            done      <= (drain_cnt == CNT_W'(1));
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_tpfu_core.sv
// tb_tpfu_core: directed vectors for tpfu_core; expected results are queued with their
// due cycle and checked by an independent monitor whenever dout_v is seen.
module tb_tpfu_core;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 6;
  localparam int PC_W     = 4;
  localparam int PIPE_LAT = 3;
  localparam int INST_W   = 3 + 3*ADDR_W;

  localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, MUL = 3'd3;
  localparam logic [2:0] PASS = 3'd4, ADDI = 3'd5, SUBI = 3'd6, MULI = 3'd7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_ready;
  logic              prog_we = 1'b0;
  logic [PC_W-1:0]   prog_addr = '0;
  logic [INST_W-1:0] prog_data = '0;
  logic [PC_W:0]     num_inst = '0;
  logic [DATA_W-1:0] dout;
  logic [ADDR_W-1:0] dout_dst;
  logic              dout_v;
  logic              busy;
  logic              done;
  logic              ovf;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] dst;
    int                cyc;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0;
  logic [DATA_W-1:0] burst [80];
  logic [INST_W-1:0] prog_buf [16];

  tpfu_core #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .PIPE_LAT(PIPE_LAT), .INST_W(INST_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .num_inst(num_inst),
    .dout(dout), .dout_dst(dout_dst), .dout_v(dout_v), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [INST_W-1:0] mk(input logic [2:0] op, input int d, input int s1, input int s2);
    return {op, ADDR_W'(d), ADDR_W'(s1), ADDR_W'(s2)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_res(input logic [DATA_W-1:0] d, input int dst, input int c);
    exp_t e;
    e.data = d;
    e.dst  = ADDR_W'(dst);
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic load_prog(input int n);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      prog_we   = 1'b1;
      prog_addr = PC_W'(i);
      prog_data = prog_buf[i];
      @(posedge clk); #1;
    end
    prog_we = 1'b0;
  endtask

  // Returns the cycle in which the first instruction issues (one past the burst-end cycle).
  task automatic send_burst(input int n, input int ninst, output int first_issue);
    int c;
    num_inst = (PC_W+1)'(ninst);
    @(posedge clk); #1;
    c = cyc;
    for (int i = 0; i < n; i++) begin
      din       = burst[i];
      din_valid = 1'b1;
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    first_issue = c + n + 1;
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_done(input int exp_cyc);
    int seen = -1;
    for (int k = 0; k < 60 && seen < 0; k++) begin
      @(negedge clk);
      if (done) seen = cyc;
    end
    check("done_cycle", seen, exp_cyc);
    @(negedge clk);
    check("done_pulse_width", done, 1'b0);
    check("din_ready_after_done", din_ready, 1'b1);
    check("busy_after_done", busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n && dout_v) begin
      if (sb.size() == 0) begin
        check("dout_v_unexpected", dout_v, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check("dout", dout, mon_e.data);
        check("dout_dst", dout_dst, mon_e.dst);
        check("dout_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_din_ready", din_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_dout_v", dout_v, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_ovf", ovf, 1'b0);
    check("reset_dout", dout, 16'h0);

    // Basic run: MULI r0,#1 and SUBI r1,#20 over burst 100,50.
    prog_buf[0] = mk(MULI, 0, 0, 1);
    prog_buf[1] = mk(SUBI, 1, 1, 20);
    load_prog(2);
    burst[0] = 16'd100;
    burst[1] = 16'd50;
    send_burst(2, 2, t0);
    expect_res(16'd100, 0, t0 + PIPE_LAT);
    expect_res(16'd30, 1, t0 + 1 + PIPE_LAT);
    wait_done(t0 + 2 + PIPE_LAT - 1);
    check("ovf_after_short_burst", ovf, 1'b0);

    // Wraparound, NOP gap, and every remaining opcode.
    prog_buf[0] = mk(SUB, 4, 1, 0);
    prog_buf[1] = mk(NOP, 0, 0, 0);
    prog_buf[2] = mk(MUL, 5, 2, 3);
    prog_buf[3] = mk(ADD, 6, 0, 1);
    prog_buf[4] = mk(PASS, 7, 2, 0);
    prog_buf[5] = mk(ADDI, 8, 1, 63);
    prog_buf[6] = mk(MULI, 9, 0, 3);
    load_prog(7);
    burst[0] = 16'd5;
    burst[1] = 16'd3;
    burst[2] = 16'd300;
    burst[3] = 16'd300;
    send_burst(4, 7, t0);
    expect_res(16'hFFFE, 4, t0 + PIPE_LAT);
    expect_res(16'h5F90, 5, t0 + 2 + PIPE_LAT);
    expect_res(16'd8, 6, t0 + 3 + PIPE_LAT);
    expect_res(16'd300, 7, t0 + 4 + PIPE_LAT);
    expect_res(16'd66, 8, t0 + 5 + PIPE_LAT);
    expect_res(16'd15, 9, t0 + 6 + PIPE_LAT);
    wait_cycle(t0 + 1 + PIPE_LAT);
    check("nop_gap_dout_v", dout_v, 1'b0);
    check("nop_gap_dout_hold", dout, 16'hFFFE);
    wait_done(t0 + 7 + PIPE_LAT - 1);

    // Zero-length program: busy for PIPE_LAT cycles, done, no results.
    burst[0] = 16'd9;
    send_burst(1, 0, t0);
    wait_cycle(t0);
    check("empty_prog_busy", busy, 1'b1);
    check("empty_prog_din_ready", din_ready, 1'b0);
    wait_done(t0 + PIPE_LAT - 1);

    // 65-word burst: words 0..63 stored, the 65th dropped, ovf set.
    for (int i = 0; i < 65; i++) burst[i] = DATA_W'(1000 + i);
    prog_buf[0] = mk(PASS, 10, 0, 0);
    prog_buf[1] = mk(PASS, 11, 63, 0);
    load_prog(2);
    send_burst(65, 2, t0);
    check("ovf_set", ovf, 1'b1);
    expect_res(16'd1000, 10, t0 + PIPE_LAT);
    expect_res(16'd1063, 11, t0 + 1 + PIPE_LAT);
    wait_done(t0 + 2 + PIPE_LAT - 1);
    check("ovf_sticky", ovf, 1'b1);

    // Reset during the second issue aborts the run without emitting anything.
    prog_buf[0] = mk(ADDI, 1, 0, 1);
    prog_buf[1] = mk(ADDI, 2, 0, 2);
    prog_buf[2] = mk(MULI, 3, 0, 4);
    load_prog(3);
    burst[0] = 16'd10;
    send_burst(1, 3, t0);
    wait_cycle(t0 + 1);
    rst_n = 1'b0;
    #1;
    check("abort_dout_v", dout_v, 1'b0);
    check("abort_dout", dout, 16'h0);
    check("abort_dout_dst", dout_dst, 6'h0);
    check("abort_busy", busy, 1'b0);
    check("abort_din_ready", din_ready, 1'b1);
    check("abort_ovf", ovf, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);

    // Program memory survives reset; the next burst runs normally.
    burst[0] = 16'd10;
    send_burst(1, 3, t0);
    expect_res(16'd11, 1, t0 + PIPE_LAT);
    expect_res(16'd12, 2, t0 + 1 + PIPE_LAT);
    expect_res(16'd40, 3, t0 + 2 + PIPE_LAT);
    wait_done(t0 + 3 + PIPE_LAT - 1);

`ifdef TPFU_WRITEBACK_EN
    // Consumer issued PIPE_LAT+1 cycles after the producer sees the written-back value.
    prog_buf[0] = mk(ADDI, 0, 0, 1);
    prog_buf[1] = mk(NOP, 0, 0, 0);
    prog_buf[2] = mk(NOP, 0, 0, 0);
    prog_buf[3] = mk(NOP, 0, 0, 0);
    prog_buf[4] = mk(ADD, 2, 0, 0);
    load_prog(5);
    burst[0] = 16'd7;
    send_burst(1, 5, t0);
    expect_res(16'd8, 0, t0 + PIPE_LAT);
    expect_res(16'd16, 2, t0 + 4 + PIPE_LAT);
    wait_done(t0 + 5 + PIPE_LAT - 1);

    // Back-to-back consumer reads the old value (no forwarding).
    prog_buf[0] = mk(ADDI, 0, 0, 1);
    prog_buf[1] = mk(ADD, 2, 0, 0);
    load_prog(2);
    burst[0] = 16'd7;
    send_burst(1, 2, t0);
    expect_res(16'd8, 0, t0 + PIPE_LAT);
    expect_res(16'd14, 2, t0 + 1 + PIPE_LAT);
    wait_done(t0 + 2 + PIPE_LAT - 1);
`endif

    repeat (4) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tpfu_core.md
Name: tpfu_core

Overview:
- Parametrised, programmable temporally-programmed functional unit (TP-FU); generalises the single-FU chebyshev datapath.
- A burst of input samples is loaded into a register file. When the burst ends, a program held in a loadable instruction memory runs one instruction per cycle through a fixed-latency ALU pipeline.
- Streams results out with destination tags.
- Sits between the xillybus FIFO adapter (din side) and the result FIFO (dout side).

Parameters:
- DATA_W, 16, datapath and register width.
- ADDR_W, 6, register-file address bits; also the immediate field width.
- PC_W, 4, program-memory address bits; max program length is 2**PC_W.
- PIPE_LAT, 3, issue-to-result latency in cycles; must be >= 1.
- INST_W, 3+3*ADDR_W, derived instruction width. Fields, MSB to LSB: opcode[3], dst[ADDR_W], src1[ADDR_W], src2/imm[ADDR_W].

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- din  in  DATA_W  input sample
- din_valid  in  1  sample strobe; the burst ends on the first cycle it is low
- din_ready  out  1  high only in LOAD state
- prog_we  in  1  program-memory write strobe
- prog_addr  in  PC_W  program-memory write address
- prog_data  in  INST_W  instruction word
- num_inst  in  PC_W+1  program length; sampled on LOAD->EXEC
- dout  out  DATA_W  result
- dout_dst  out  ADDR_W  destination tag of the result
- dout_v  out  1  result valid
- busy  out  1  high in EXEC or DRAIN
- done  out  1  one-cycle pulse at end of DRAIN
- ovf  out  1  sticky: a burst exceeded 2**ADDR_W words

Behaviour:
- Reset (async assert, sync release):
  - State = LOAD; wr_cnt, pc and pipeline valids cleared.
  - Outputs: dout=0, dout_dst=0, dout_v=0, busy=0, done=0, ovf=0, din_ready=1.
  - Register file and program memory are NOT reset; contents are retained.
  - Reset mid-EXEC or mid-DRAIN aborts the run; in-flight results are never emitted.
- LOAD state:
  - Each cycle with din_valid=1: regfile[wr_cnt] <= din, then wr_cnt++.
  - Once wr_cnt reaches 2**ADDR_W, further words are dropped and ovf is set. ovf clears only on reset.
  - Burst end is the first cycle with din_valid=0 after at least one accepted word. Next state is EXEC; pc=0; num_inst is latched; wr_cnt=0.
  - din_valid=0 with no words accepted: stay in LOAD.
- EXEC state:
  - Each cycle, issue imem[pc]. Source operands are read in the issue cycle.
  - pc++ each cycle. After issuing pc==num_inst-1, go to DRAIN.
  - Latched num_inst==0: go directly to DRAIN with nothing issued.
  - num_inst > 2**PC_W is clamped to 2**PC_W.
- DRAIN state:
  - Wait until the pipeline is empty, i.e. PIPE_LAT cycles after the last issue.
  - Then pulse done for one cycle and return to LOAD.
  - din_ready=0 throughout EXEC and DRAIN; din_valid is ignored there.
- Program writes:
  - prog_we is accepted in LOAD only and ignored while busy.
  - A write and an EXEC read never collide.
- Opcodes (a=src1 reg, b=src2 reg, imm=src2 field zero-extended):
  - 000 NOP
  - 001 ADD a+b
  - 010 SUB a-b
  - 011 MUL a*b
  - 100 PASS a
  - 101 ADDI a+imm
  - 110 SUBI a-imm
  - 111 MULI a*imm
- Arithmetic:
  - Unsigned/two's-complement wrap, truncated to DATA_W.
  - MUL/MULI return the low DATA_W bits of the product.
- Latency and output:
  - An instruction issued in cycle t drives dout, dout_dst and dout_v=1 in cycle t+PIPE_LAT.
  - NOP occupies a slot and produces dout_v=0.
  - dout and dout_dst hold their last value while dout_v=0.
- A burst arriving while busy is not accepted (din_ready=0). Upstream must hold it off.

Optional Feature:
- Macro: TPFU_WRITEBACK_EN.
- Defined:
  - Each valid result is also written to regfile[dout_dst] in the cycle dout_v is high.
  - No forwarding: an instruction issued fewer than PIPE_LAT+1 cycles after its producer reads the old value.
  - Writeback and LOAD writes never overlap, since writeback occurs only in EXEC/DRAIN.
- Undefined: results leave only via dout; the register file is written solely by din.

Test Plan:
- Reset release, no stimulus:
  - din_ready=1, busy=0, dout_v=0, done=0, ovf=0.
- Program load and basic run:
  - Load prog[0]=MULI r0,#1 and prog[1]=SUBI r1,#20 (i.e. imm=20); num_inst=2.
  - Burst din=100,50.
  - Required: dout_v at issue+3 giving 100 (dst 0), then 30 (dst 1); done 3 cycles after the last issue; din_ready returns 1.
- Wrap and NOP:
  - SUB r1-r0 with r0=5, r1=3 gives 16'hFFFE.
  - MUL 300*300 gives 16'h5F90.
  - A NOP between them leaves a one-cycle dout_v gap.
- Boundary:
  - num_inst=0 gives busy for PIPE_LAT cycles, done, and no dout_v.
  - A 65-word burst with ADDR_W=6 stores words 0..63 and sets ovf.
- Reset mid-EXEC:
  - Assert rst_n=0 at the 2nd issue; outputs clear immediately and no dout_v follows.
  - A subsequent burst runs normally.
- TPFU_WRITEBACK_EN:
  - ADDI r0,#1 then, 4 cycles later, ADD r2=r0+r0 with r0=7 gives 16.
  - Same pair issued back-to-back gives 14.
